spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front end that drives the single-port RAM command bus from the serial side.
//  - Deserialises MOSI frames into 10-bit commands {cmd[1:0], payload[7:0]} on rx_data/rx_valid.
//  - Accepts the RAM read response on tx_data/tx_valid and serialises it MSB-first on MISO.
//  - Serial bit rate equals clk: one bit per posedge while SS_n is low.
// PARAMETERS
//  DATA_W  8  payload / read-data width; rx_data width is DATA_W+2
// PORTS
//  clk       in   1         system clock (also the SPI bit clock)
//  rst_n     in   1         reset, synchronous, active-low
//  SS_n      in   1         slave select, active-low; high aborts/ends any frame
//  MOSI      in   1         serial data in, sampled at posedge clk
//  MISO      out  1         serial data out, registered
//  rx_data   out  DATA_W+2  command word to RAM: [9:8] = cmd, [7:0] = address or data
//  rx_valid  out  1         one-cycle strobe, rx_data valid
//  tx_data   in   DATA_W    read data from RAM
//  tx_valid  in   1         tx_data valid; sampled only in READ_DATA after rx_valid
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state = IDLE, MISO = 0, rx_data = 0, rx_valid = 0, bit counter = 0, rd_addr_done = 0.
//  FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n=1 sampled in any state -> IDLE next edge.
//   - IDLE: SS_n=0 -> CHK_CMD.
//   - CHK_CMD: the MOSI bit at this edge is the route bit and is not stored.
//     0 -> WRITE; 1 & !rd_addr_done -> READ_ADD; 1 & rd_addr_done -> READ_DATA.
//   - WRITE / READ_ADD / READ_DATA: shift the next 10 MOSI bits MSB-first into the shift register.
//     On the edge sampling the 10th bit, rx_data <= full word and rx_valid <= 1 for exactly one cycle.
//     Extra MOSI bits are ignored until SS_n rises.
//   - READ_ADD: on the 10th bit, rd_addr_done <= 1.
//   - READ_DATA, after rx_valid: wait (unbounded) for tx_valid=1.
//     At that edge, latch tx_data and set MISO <= tx_data[7]. The next 7 edges drive bits [6:0].
//     The following edge sets MISO <= 0 and rd_addr_done <= 0. Later tx_valid pulses are ignored.
//  Latency:
//   - rx_valid goes high at edge 11 after CHK_CMD: 1 route bit + 10 shifted bits.
//   - The first MISO bit appears at the edge that samples tx_valid.
//  MISO is 0 whenever the block is not shifting read data.
//  Abort (SS_n high mid-frame):
//   - No rx_valid. Shift register and counter clear. rd_addr_done is unchanged.
//   - MISO <= 0 and the read-data transfer is dropped; rd_addr_done stays 1.
//  Reset mid-frame: same as power-on reset; rd_addr_done cleared.
//  rx_data holds its last value between strobes. The RAM decodes the cmd bits; this block does not check them.
// TESTING
//  1 Reset: rst_n=0 for 2 clk with SS_n=0 and MOSI toggling -> MISO=0, rx_valid=0, rx_data=0, state IDLE.
//  2 Write address:
//    SS_n=0, MOSI = 0 then 00_1111_1110 -> rx_data=10'h0FE and rx_valid=1 for one cycle, 11 edges after CHK_CMD.
//    Then SS_n=1 -> back to IDLE.
//  3 Write data: MOSI = 0 then 01_1010_0101 -> rx_data=10'h1A5 and one rx_valid pulse; rd_addr_done stays 0.
//  4 Read sequence:
//    Frame 1: MOSI = 1 then 10_1111_1110 -> rx_data=10'h2FE, then rd_addr_done=1.
//    Frame 2: MOSI = 1 then 11_xxxx_xxxx -> rx_data[9:8]=2'b11.
//    tx_valid=1 with tx_data=8'hC3 one cycle later -> MISO = 1,1,0,0,0,0,1,1 on successive edges, then 0.
//    A following read frame routes to READ_ADD.
//  5 Abort:
//    SS_n rises after 5 payload bits of a WRITE -> no rx_valid.
//    Next full frame decodes correctly; a read-address frame aborted mid-way leaves rd_addr_done as before.
//  6 Back-to-back: SS_n=1 for a single cycle between two write frames -> two rx_valid pulses with correct rx_data.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit RAM commands from MOSI and serialises
// RAM read data back out on MISO, one bit per clock while slave select is low.
module spi_slave_if #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [DATA_W+1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid
);

  localparam int unsigned RxW    = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(RxW + 1);
  localparam int unsigned TxCntW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [RxW-1:0]      r_shift;
  logic [CntW-1:0]     r_cnt;
  logic [RxW-1:0]      r_rx_data;
  logic                r_rx_valid;
  logic                r_rd_addr_done;
  logic                r_miso;
  logic [DATA_W-1:0]   r_tx_sr;
  logic [TxCntW-1:0]   r_tx_cnt;
  logic                r_tx_busy;
  logic                r_tx_done;
  logic                w_in_frame;
  logic                w_shifting;
  logic                w_last_bit;
  logic                w_rx_full;
  logic [RxW-1:0]      w_word;

  assign w_in_frame = (r_state == StWrite) || (r_state == StReadAdd) || (r_state == StReadData);
  assign w_rx_full  = (r_cnt == CntW'(RxW));
  assign w_shifting = w_in_frame && !i_ss_n && !w_rx_full;
  assign w_last_bit = w_shifting && (r_cnt == CntW'(RxW - 1));
  assign w_word     = {r_shift[RxW-2:0], i_mosi};

  always_comb begin
    w_state_next = r_state;
    if (i_ss_n) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:   w_state_next = StChkCmd;
        // The route bit is consumed here and never reaches the shift register.
        StChkCmd: begin
          if (!i_mosi)             w_state_next = StWrite;
          else if (r_rd_addr_done) w_state_next = StReadData;
          else                     w_state_next = StReadAdd;
        end
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_miso         <= 1'b0;
      r_tx_sr        <= '0;
      r_tx_cnt       <= '0;
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rx_valid <= 1'b0;
      if (i_ss_n) begin
        // Abort drops the frame and any read transfer but keeps rd_addr_done.
        r_shift   <= '0;
        r_cnt     <= '0;
        r_miso    <= 1'b0;
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b0;
      end else begin
        if (w_shifting) begin
          r_shift <= w_word;
          r_cnt   <= r_cnt + CntW'(1);
        end
        if (w_last_bit) begin
          r_rx_data  <= w_word;
          r_rx_valid <= 1'b1;
          if (r_state == StReadAdd) r_rd_addr_done <= 1'b1;
        end
        if (r_state == StReadData && w_rx_full) begin
          if (r_tx_busy) begin
            if (r_tx_cnt != '0) begin
              r_miso   <= r_tx_sr[DATA_W-1];
              r_tx_sr  <= {r_tx_sr[DATA_W-2:0], 1'b0};
              r_tx_cnt <= r_tx_cnt - TxCntW'(1);
            end else begin
              r_miso         <= 1'b0;
              r_tx_busy      <= 1'b0;
              r_tx_done      <= 1'b1;
              r_rd_addr_done <= 1'b0;
            end
          end else if (!r_tx_done && i_tx_valid) begin
            r_miso    <= i_tx_data[DATA_W-1];
            r_tx_sr   <= {i_tx_data[DATA_W-2:0], 1'b0};
            r_tx_cnt  <= TxCntW'(DATA_W - 1);
            r_tx_busy <= 1'b1;
          end
        end
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: command framing, read-data serialisation,
// abort and reset handling, checked against hand-computed values.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;
  int n_pulses = 0;
  logic [9:0] last_word = 10'h000;

  spi_slave_if #(.DATA_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ss_n     (ss_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid) n_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full frame (nbits == 10) leaves SS_n low right after the rx_valid edge;
  // a partial frame is aborted by raising SS_n.
  task automatic send_frame(input logic route, input logic [9:0] word, input int nbits);
    int base;
    ss_n = 1'b0;
    mosi = 1'b0;
    step();
    mosi = route;
    step();
    check_eq("no_strobe_on_route", 32'(rx_valid), 0);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[9-i];
      step();
      if (i < 9) check_eq("no_early_strobe", 32'(rx_valid), 0);
    end
    if (nbits == 10) begin
      check_eq("rx_valid", 32'(rx_valid), 1);
      check_eq("rx_data", 32'(rx_data), 32'(word));
      last_word = word;
      mosi = 1'b1;
    end else begin
      base = n_pulses;
      ss_n = 1'b1;
      step();
      step();
      check_eq("abort_no_strobe", n_pulses, base);
      check_eq("abort_miso", 32'(miso), 0);
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    step();
    check_eq("rx_valid_one_cycle", 32'(rx_valid), 0);
    check_eq("rx_data_held", 32'(rx_data), 32'(last_word));
  endtask

  task automatic tx_read(input logic [7:0] data, input logic expect_out);
    tx_data  = data;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_eq("rx_valid_one_cycle", 32'(rx_valid), 0);
    check_eq("miso_bit7", 32'(miso), expect_out ? 32'(data[7]) : 0);
    for (int i = 6; i >= 0; i--) begin
      step();
      check_eq("miso_bit", 32'(miso), expect_out ? 32'(data[i]) : 0);
    end
    step();
    check_eq("miso_after_byte", 32'(miso), 0);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_eq("tx_valid_ignored", 32'(miso), 0);
    step();
    check_eq("tx_valid_ignored2", 32'(miso), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ss_n     = 1'b0;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // Reset with SS_n low and MOSI toggling
    step();
    mosi = 1'b1;
    step();
    check_eq("reset_miso", 32'(miso), 0);
    check_eq("reset_rx_valid", 32'(rx_valid), 0);
    check_eq("reset_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    step();

    // Back-to-back write address / write data, single-cycle SS_n gap
    send_frame(1'b0, 10'h0FE, 10);
    end_frame();
    send_frame(1'b0, 10'h1A5, 10);
    end_frame();

    // Read address: must route to READ_ADD (rd_addr_done still 0), tx_valid ignored
    send_frame(1'b1, 10'h2FE, 10);
    tx_read(8'hC3, 1'b0);
    end_frame();
    // Read data: now routes to READ_DATA
    send_frame(1'b1, 10'h300, 10);
    check_eq("read_cmd_bits", 32'(rx_data[9:8]), 3);
    tx_read(8'hC3, 1'b1);
    end_frame();
    // rd_addr_done cleared after the byte: back to READ_ADD
    send_frame(1'b1, 10'h2AA, 10);
    tx_read(8'h81, 1'b0);
    end_frame();

    // Aborted write, then a full write decodes correctly
    send_frame(1'b0, 10'h1FF, 5);
    send_frame(1'b0, 10'h155, 10);
    end_frame();

    // Aborted read-data frame keeps rd_addr_done = 1
    send_frame(1'b1, 10'h3FF, 4);
    // Read-data transfer aborted after three bits of 8'h5A
    send_frame(1'b1, 10'h300, 10);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_eq("abort_tx_b7", 32'(miso), 0);
    step();
    check_eq("abort_tx_b6", 32'(miso), 1);
    step();
    check_eq("abort_tx_b5", 32'(miso), 0);
    ss_n = 1'b1;
    step();
    check_eq("abort_tx_miso", 32'(miso), 0);
    // rd_addr_done still 1: full read-data byte
    send_frame(1'b1, 10'h300, 10);
    tx_read(8'h81, 1'b1);
    end_frame();

    // Aborted read-address frame keeps rd_addr_done = 0
    send_frame(1'b1, 10'h2FF, 4);
    send_frame(1'b1, 10'h2AA, 10);
    tx_read(8'hFF, 1'b0);
    end_frame();

    // Reset mid-frame clears rd_addr_done and outputs
    ss_n = 1'b0;
    mosi = 1'b0;
    step();
    mosi = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    check_eq("midreset_rx_data", 32'(rx_data), 0);
    check_eq("midreset_miso", 32'(miso), 0);
    rst_n = 1'b1;
    ss_n  = 1'b1;
    step();
    last_word = 10'h000;
    send_frame(1'b1, 10'h2CC, 10);
    tx_read(8'hFF, 1'b0);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
